// File: rtl/jk_mod_counter_pkg.sv
// Shared constants for the JK-flop based modulo up/down counter.
package jk_mod_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 4;
  localparam int unsigned DEFAULT_MODULUS = 10;

  // JK next-state function, encoded as {j, k}
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_t;

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// Single-bit JK flip-flop with asynchronous active-low reset.
module jk_cell
  import jk_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  jk_op_t op;

  assign op = jk_op_t'({j, k});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case (op)
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter with saturating parallel load, built from JK stages.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] load_tgt;
  logic             q_over;
  logic             at_max;
  logic             at_zero;

  assign load_tgt = ({1'b0, din} >= MOD_EXT) ? MAX_VAL : din;
  assign q_over   = ({1'b0, q} >= MOD_EXT);
  assign at_max   = (q == MAX_VAL);
  assign at_zero  = (q == '0);

  assign tc = !load && en && ((up && at_max) || (!up && at_zero));

  // Loads and wraps drive J/K straight at a target; ordinary steps toggle only changing bits
  always_comb begin
    j = '0;
    k = '0;
    if (load) begin
      j = load_tgt;
      k = ~load_tgt;
    end else if (en) begin
      if (up) begin
        if (at_max || q_over) begin
          j = '0;
          k = '1;
        end else begin
          j = q ^ (q + WIDTH'(1));
          k = q ^ (q + WIDTH'(1));
        end
      end else begin
        if (at_zero || q_over) begin
          j = MAX_VAL;
          k = ~MAX_VAL;
        end else begin
          j = q ^ (q - WIDTH'(1));
          k = q ^ (q - WIDTH'(1));
        end
      end
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i])
    );
  end

endmodule

// File: doc/jk_mod_counter.md
JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter and load-data width in bits.
REQ-002 SHALL have parameter MODULUS, default 10, giving the count range 0..MODULUS-1, with 2 <= MODULUS <= 2^WIDTH.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: en  input  1  count enable.
REQ-006 SHALL have port: up  input  1  direction; 1 counts up, 0 counts down.
REQ-007 SHALL have port: load  input  1  synchronous parallel load request.
REQ-008 SHALL have port: din  input  WIDTH  parallel load value.
REQ-009 SHALL have port: q  output  WIDTH  current count, taken directly from the flop outputs.
REQ-010 SHALL have port: tc  output  1  terminal-count flag (combinational).

Function
REQ-011 SHALL hold each bit of q in one JK stage, driven only through that stage's J and K inputs; no direct D-path to q.
REQ-012 SHALL apply this per-edge priority: load first, then en, otherwise hold.
REQ-013 On load=1: next q SHALL be din, or MODULUS-1 if din >= MODULUS; implemented per bit as J=target, K=~target. en and up are ignored in that cycle.
REQ-014 On load=0, en=1, up=1: next q SHALL be q+1, except q=MODULUS-1, which wraps to 0.
REQ-015 On load=0, en=1, up=0: next q SHALL be q-1, except q=0, which wraps to MODULUS-1.
REQ-016 Normal count steps SHALL drive J=K=1 on the bits that must toggle and J=K=0 on the others; wrap steps SHALL use the load-style J/K encoding toward the wrap target.
REQ-017 On load=0, en=0: both J and K SHALL be 0 on every bit, so q holds.
REQ-018 tc SHALL be 1 exactly when load=0, en=1, and either (up=1 and q=MODULUS-1) or (up=0 and q=0); otherwise tc is 0.
REQ-019 A change of up takes effect on the next edge, with no dead cycle.
REQ-020 Latency SHALL be one clock edge from the control inputs to the updated q.
REQ-021 If q ever holds a value >= MODULUS, the next enabled count SHALL load 0 when counting up or MODULUS-1 when counting down.

Reset
REQ-022 reset=0 SHALL force q=0 immediately, independent of clk; tc then follows REQ-018.
REQ-023 A reset asserted mid-count SHALL abort the sequence; after release, the first edge with en=1 and up=1 yields q=1.
REQ-024 Every JK stage SHALL use the same asynchronous active-low reset; no synchronous clear exists.

Structure
REQ-025 The JK next-state function (00 hold, 01 reset, 10 set, 11 toggle) SHALL be encoded as named constants in the shared package, together with the default WIDTH and MODULUS.
REQ-026 The design SHALL instantiate one sub-module, jk_cell (a single-bit JK flop with clk and active-low asynchronous reset), WIDTH times via generate.
REQ-027 All J/K generation logic SHALL reside in jk_mod_counter; jk_cell contains no counting logic.

Verification
REQ-028 Reset sequence: reset=0 at q=6, no clk edge -> q=0 within the same time step; tc=0 while en=0.
REQ-029 Up-count wrap: en=1, up=1 for 11 edges from q=0 -> q steps 1..9, 0, 1; tc=1 only while q=9.
REQ-030 Down-count wrap: en=1, up=0 from q=0 -> tc=1 before the edge, then q=9, 8, 7.
REQ-031 Load priority and saturation: load=1, din=7, en=1, up=1 -> q=7; load=1, din=12 -> q=9.
REQ-032 Hold and direction change: en=0 for 3 edges at q=4 -> q=4; then en=1 with up toggled each edge -> q=5, 4, 5.
REQ-033 Reset mid-load: reset=0 asserted between load setup and the clk edge -> q=0, and the load is discarded.
